// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Groups the per-frame configuration inputs and the raster outputs of
//   video_timing_gen.
//   master : the timing generator (reads config, drives video)
//   slave  : the consumer/controller (drives config, reads video)
//   Config : i_en, i_pat_sel, i_vsw/i_vbp/i_vact/i_vfp, i_hsw/i_hbp/i_hact/i_hfp
//   Video  : o_vsync, o_hsync, o_de, o_red/o_green/o_blue, o_frame_done
interface video_timing_gen_if #(
   parameter int unsigned VER_WIDTH = 6,
   parameter int unsigned HOR_WIDTH = 6,
   parameter int unsigned RGB_WIDTH = 10
);
   logic                 i_en;
   logic [1:0]           i_pat_sel;
   logic [VER_WIDTH-1:0] i_vsw;
   logic [VER_WIDTH-1:0] i_vbp;
   logic [VER_WIDTH-1:0] i_vact;
   logic [VER_WIDTH-1:0] i_vfp;
   logic [HOR_WIDTH-1:0] i_hsw;
   logic [HOR_WIDTH-1:0] i_hbp;
   logic [HOR_WIDTH-1:0] i_hact;
   logic [HOR_WIDTH-1:0] i_hfp;
   logic                 o_vsync;
   logic                 o_hsync;
   logic                 o_de;
   logic [RGB_WIDTH-1:0] o_red;
   logic [RGB_WIDTH-1:0] o_green;
   logic [RGB_WIDTH-1:0] o_blue;
   logic                 o_frame_done;

   modport master (
      input  i_en, i_pat_sel, i_vsw, i_vbp, i_vact, i_vfp,
             i_hsw, i_hbp, i_hact, i_hfp,
      output o_vsync, o_hsync, o_de, o_red, o_green, o_blue, o_frame_done
   );

   modport slave (
      output i_en, i_pat_sel, i_vsw, i_vbp, i_vact, i_vfp,
             i_hsw, i_hbp, i_hact, i_hfp,
      input  o_vsync, o_hsync, o_de, o_red, o_green, o_blue, o_frame_done
   );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Programmable raster source. Generates vsync/hsync/de and an RGB test
//   pattern from timing fields latched at every frame start.
//   clk  : single clock
//   rst  : asynchronous, active-high reset
//   vif  : video_timing_gen_if.master (config in, registered video out)
module video_timing_gen #(
   parameter int unsigned VER_WIDTH = 6,
   parameter int unsigned HOR_WIDTH = 6,
   parameter int unsigned RGB_WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst,
   video_timing_gen_if.master vif
);
   localparam int unsigned HW2 = HOR_WIDTH + 2;
   localparam int unsigned VW2 = VER_WIDTH + 2;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t state, state_nxt;
   logic   load;

   // Shadow config is kept as cumulative phase boundaries so the phase of
   // the current position is a plain compare against the counters.
   logic [HW2-1:0]       h_cnt, s_hsw, s_hb, s_ha, s_hlast;
   logic [VW2-1:0]       v_cnt, s_vsw, s_vb, s_va, s_vlast;
   logic [1:0]           s_pat;
   logic [RGB_WIDTH-1:0] frame_cnt;

   logic [HW2-1:0]       n_hb, n_ha, n_hsum, n_hlast;
   logic [VW2-1:0]       n_vb, n_va, n_vsum, n_vlast;

   logic                 line_end, frame_end;
   logic                 vs_c, hs_c, de_c;
   logic [HOR_WIDTH-1:0] x_c;
   logic [VER_WIDTH-1:0] y_c;
   logic [RGB_WIDTH-1:0] rx, ry, r_c, g_c, b_c;

   // A zero-length line/frame collapses to a single blank cycle/line.
   always_comb begin
      n_hb    = HW2'(vif.i_hsw) + HW2'(vif.i_hbp);
      n_ha    = n_hb + HW2'(vif.i_hact);
      n_hsum  = n_ha + HW2'(vif.i_hfp);
      n_hlast = (n_hsum == '0) ? '0 : n_hsum - HW2'(1);
      n_vb    = VW2'(vif.i_vsw) + VW2'(vif.i_vbp);
      n_va    = n_vb + VW2'(vif.i_vact);
      n_vsum  = n_va + VW2'(vif.i_vfp);
      n_vlast = (n_vsum == '0) ? '0 : n_vsum - VW2'(1);
   end

   assign line_end  = (h_cnt == s_hlast);
   assign frame_end = (state == ST_RUN) && line_end && (v_cnt == s_vlast);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vif.i_en) begin
               state_nxt = ST_RUN;
               load      = 1'b1;
            end
         end
         ST_RUN: begin
            if (frame_end) begin
               if (vif.i_en) load      = 1'b1;
               else          state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         s_hsw   <= '0;
         s_hb    <= '0;
         s_ha    <= '0;
         s_hlast <= '0;
         s_vsw   <= '0;
         s_vb    <= '0;
         s_va    <= '0;
         s_vlast <= '0;
         s_pat   <= '0;
      end else if (load) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         s_hsw   <= HW2'(vif.i_hsw);
         s_hb    <= n_hb;
         s_ha    <= n_ha;
         s_hlast <= n_hlast;
         s_vsw   <= VW2'(vif.i_vsw);
         s_vb    <= n_vb;
         s_va    <= n_va;
         s_vlast <= n_vlast;
         s_pat   <= vif.i_pat_sel;
      end else if (state == ST_RUN) begin
         if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == s_vlast) ? '0 : v_cnt + VW2'(1);
         end else begin
            h_cnt <= h_cnt + HW2'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            frame_cnt <= '0;
      else if (frame_end) frame_cnt <= frame_cnt + RGB_WIDTH'(1);
   end

   // Raster decode of the current position; registered below.
   always_comb begin
      vs_c = (v_cnt < s_vsw);
      hs_c = (h_cnt < s_hsw);
      de_c = (v_cnt >= s_vb) && (v_cnt < s_va) &&
             (h_cnt >= s_hb) && (h_cnt < s_ha);
      x_c  = HOR_WIDTH'(h_cnt - s_hb);
      y_c  = VER_WIDTH'(v_cnt - s_vb);
      rx   = RGB_WIDTH'(x_c);
      ry   = RGB_WIDTH'(y_c);
      r_c  = '0;
      g_c  = '0;
      b_c  = '0;
      if (de_c) begin
         case (s_pat)
            2'd0: begin r_c = rx;      g_c = rx;      b_c = rx;        end
            2'd1: begin r_c = ry;      g_c = ry;      b_c = ry;        end
            2'd2: begin r_c = rx ^ ry; g_c = rx ^ ry; b_c = rx ^ ry;   end
            default: begin r_c = rx;   g_c = ry;      b_c = frame_cnt; end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vif.o_vsync      <= 1'b0;
         vif.o_hsync      <= 1'b0;
         vif.o_de         <= 1'b0;
         vif.o_red        <= '0;
         vif.o_green      <= '0;
         vif.o_blue       <= '0;
         vif.o_frame_done <= 1'b0;
      end else if (state == ST_RUN) begin
         vif.o_vsync      <= vs_c;
         vif.o_hsync      <= hs_c;
         vif.o_de         <= de_c;
         vif.o_red        <= r_c;
         vif.o_green      <= g_c;
         vif.o_blue       <= b_c;
         vif.o_frame_done <= frame_end;
      end else begin
         vif.o_vsync      <= 1'b0;
         vif.o_hsync      <= 1'b0;
         vif.o_de         <= 1'b0;
         vif.o_red        <= '0;
         vif.o_green      <= '0;
         vif.o_blue       <= '0;
         vif.o_frame_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen. Each captured cycle is packed as
//   {vsync, hsync, de, frame_done, red, green, blue} and compared against a
//   hand-derived expectation for the scenario's raster geometry.
module tb_video_timing_gen;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [33:0] cap [0:255];

   video_timing_gen_if #(.VER_WIDTH(6), .HOR_WIDTH(6), .RGB_WIDTH(10)) vif ();

   video_timing_gen #(.VER_WIDTH(6), .HOR_WIDTH(6), .RGB_WIDTH(10)) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   function automatic logic [33:0] pack(input logic vs, input logic hs, input logic de,
                                        input logic done, input logic [9:0] r,
                                        input logic [9:0] g, input logic [9:0] b);
      return {vs, hs, de, done, r, g, b};
   endfunction

   task automatic set_timing(input int hsw, input int hbp, input int hact, input int hfp,
                             input int vsw, input int vbp, input int vact, input int vfp,
                             input int pat);
      vif.i_hsw     = 6'(hsw);
      vif.i_hbp     = 6'(hbp);
      vif.i_hact    = 6'(hact);
      vif.i_hfp     = 6'(hfp);
      vif.i_vsw     = 6'(vsw);
      vif.i_vbp     = 6'(vbp);
      vif.i_vact    = 6'(vact);
      vif.i_vfp     = 6'(vfp);
      vif.i_pat_sel = 2'(pat);
   endtask

   // Raises en, lets the start edge pass, then records n cycles; cap[0]
   // holds position (0,0). At drop_idx en is lowered and hact optionally
   // rewritten to probe mid-frame config changes.
   task automatic capture(input int n, input int drop_idx, input int new_hact);
      vif.i_en = 1'b1;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cap[i] = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_done,
                   vif.o_red, vif.o_green, vif.o_blue};
         if (i == drop_idx) begin
            vif.i_en = 1'b0;
            if (new_hact != 0) vif.i_hact = 6'(new_hact);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst      = 1'b1;
      vif.i_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [33:0] obs;
      rst = 1'b1;
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 0);
      vif.i_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         obs = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_done,
                vif.o_red, vif.o_green, vif.o_blue};
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold[%0d] got %h exp 0", i, obs);
         end
      end
      @(negedge clk);
      vif.i_en = 1'b0;
      rst      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         obs = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_done,
                vif.o_red, vif.o_green, vif.o_blue};
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL idle_after_reset[%0d] got %h exp 0", i, obs);
         end
      end
   endtask

   // 8-cycle lines (hsync c0-1, hbp c2, act c3-6, hfp c7), 5-line frame.
   task automatic test_pattern_x();
      int l, c;
      logic de;
      logic [9:0] v;
      logic [33:0] exp;
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 0);
      capture(42, 0, 0);
      for (int i = 0; i < 42; i++) begin
         l   = i / 8;
         c   = i % 8;
         de  = (i < 40) && (l == 2 || l == 3) && (c >= 3 && c <= 6);
         v   = de ? 10'(c - 3) : 10'd0;
         exp = pack(i < 8, (i < 40) && (c < 2), de, i == 39, v, v, v);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL pattern_x[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_pattern_y();
      int l, c;
      logic de;
      logic [9:0] v;
      logic [33:0] exp;
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 1);
      capture(42, 0, 0);
      for (int i = 0; i < 42; i++) begin
         l   = i / 8;
         c   = i % 8;
         de  = (i < 40) && (l == 2 || l == 3) && (c >= 3 && c <= 6);
         v   = de ? 10'(l - 2) : 10'd0;
         exp = pack(i < 8, (i < 40) && (c < 2), de, i == 39, v, v, v);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL pattern_y[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   // hbp=0, vfp=0: 7-cycle lines, 4 lines; de directly follows hsync.
   task automatic test_pattern_xor_zero_phase();
      int l, c;
      logic de;
      logic [9:0] v;
      logic [33:0] exp;
      set_timing(2, 0, 4, 1, 1, 1, 2, 0, 2);
      capture(30, 0, 0);
      for (int i = 0; i < 30; i++) begin
         l   = i / 7;
         c   = i % 7;
         de  = (i < 28) && (l == 2 || l == 3) && (c >= 2 && c <= 5);
         v   = de ? 10'((c - 2) ^ (l - 2)) : 10'd0;
         exp = pack(i < 7, (i < 28) && (c < 2), de, i == 27, v, v, v);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL pattern_xor[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int f, j, l, c;
      logic act, de;
      logic [33:0] exp;
      apply_reset();
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 3);
      capture(122, 80, 0);
      for (int i = 0; i < 122; i++) begin
         f   = i / 40;
         j   = i % 40;
         l   = j / 8;
         c   = j % 8;
         act = (i < 120);
         de  = act && (l == 2 || l == 3) && (c >= 3 && c <= 6);
         exp = pack(act && (j < 8), act && (c < 2), de, act && (j == 39),
                    de ? 10'(c - 3) : 10'd0, de ? 10'(l - 2) : 10'd0,
                    de ? 10'(f) : 10'd0);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL back_to_back[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_mid_frame_change();
      int l, c;
      logic de;
      logic [9:0] v;
      logic [33:0] exp;
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 0);
      capture(42, 5, 2);
      for (int i = 0; i < 42; i++) begin
         l   = i / 8;
         c   = i % 8;
         de  = (i < 40) && (l == 2 || l == 3) && (c >= 3 && c <= 6);
         v   = de ? 10'(c - 3) : 10'd0;
         exp = pack(i < 8, (i < 40) && (c < 2), de, i == 39, v, v, v);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL mid_change_old[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
      capture(32, 0, 0);
      for (int i = 0; i < 32; i++) begin
         l   = i / 6;
         c   = i % 6;
         de  = (i < 30) && (l == 2 || l == 3) && (c >= 3 && c <= 4);
         v   = de ? 10'(c - 3) : 10'd0;
         exp = pack(i < 6, (i < 30) && (c < 2), de, i == 29, v, v, v);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL mid_change_new[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int l, c;
      logic de;
      logic [33:0] obs, exp;
      set_timing(2, 1, 4, 1, 1, 1, 2, 1, 3);
      capture(21, 0, 0);
      // five frames completed since the last reset
      exp = pack(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 10'd5);
      checks++;
      if (cap[19] !== exp) begin
         errors++;
         $display("FAIL pre_reset_pixel got %h exp %h", cap[19], exp);
      end
      rst = 1'b1;
      #1;
      obs = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_done,
             vif.o_red, vif.o_green, vif.o_blue};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_async_clear got %h exp 0", obs);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         obs = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_done,
                vif.o_red, vif.o_green, vif.o_blue};
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold[%0d] got %h exp 0", i, obs);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      capture(42, 0, 0);
      for (int i = 0; i < 42; i++) begin
         l   = i / 8;
         c   = i % 8;
         de  = (i < 40) && (l == 2 || l == 3) && (c >= 3 && c <= 6);
         exp = pack(i < 8, (i < 40) && (c < 2), de, i == 39,
                    de ? 10'(c - 3) : 10'd0, de ? 10'(l - 2) : 10'd0, 10'd0);
         checks++;
         if (cap[i] !== exp) begin
            errors++;
            $display("FAIL restart_after_reset[%0d] got %h exp %h", i, cap[i], exp);
         end
      end
   endtask

   initial begin
      vif.i_en = 1'b0;
      test_reset();
      test_pattern_x();
      test_pattern_y();
      test_pattern_xor_zero_phase();
      test_back_to_back();
      test_mid_frame_change();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
